// File: rtl/blackjack_pkg.sv
// Shared definitions for the blackjack round controller: state encoding,
// result codes, game constants and the soft-ace scoring helper.
package blackjack_pkg;

  localparam logic [3:0] ST_IDLE        = 4'd0;
  localparam logic [3:0] ST_DEAL_P1     = 4'd1;
  localparam logic [3:0] ST_DEAL_D1     = 4'd2;
  localparam logic [3:0] ST_DEAL_P2     = 4'd3;
  localparam logic [3:0] ST_DEAL_D2     = 4'd4;
  localparam logic [3:0] ST_PLAYER_TURN = 4'd5;
  localparam logic [3:0] ST_P_DRAW      = 4'd6;
  localparam logic [3:0] ST_DEALER_TURN = 4'd7;
  localparam logic [3:0] ST_D_DRAW      = 4'd8;
  localparam logic [3:0] ST_RESULT      = 4'd9;

  localparam logic [1:0] RES_NONE   = 2'b00;
  localparam logic [1:0] RES_PLAYER = 2'b01;
  localparam logic [1:0] RES_DEALER = 2'b10;
  localparam logic [1:0] RES_PUSH   = 2'b11;

  localparam int BUST_LIMIT = 21;
  localparam int DECK_SIZE  = 52;
  localparam int ACE_BONUS  = 10;

  // One ace may count as 11 whenever that does not push the hand past 21.
  function automatic logic [4:0] best_score(input logic [4:0] hard, input logic has_ace);
    if (has_ace && hard <= 5'(BUST_LIMIT - ACE_BONUS)) begin
      return hard + 5'(ACE_BONUS);
    end
    return hard;
  endfunction

endpackage

// File: rtl/blackjack_hand_fsm_if.sv
// Control/score bundle between the game controller (slave) and whatever
// drives the buttons and LFSR value (master).
interface blackjack_hand_fsm_if #(
  parameter int RND_W   = 6,
  parameter int SCORE_W = 7
);
  logic [RND_W-1:0]   rnd;
  logic               deal;
  logic               hit;
  logic               stand;
  logic [SCORE_W-1:0] player_score;
  logic [SCORE_W-1:0] dealer_score;
  logic [1:0]         result;
  logic               busy;

  modport master (
    output rnd, deal, hit, stand,
    input  player_score, dealer_score, result, busy
  );

  modport slave (
    input  rnd, deal, hit, stand,
    output player_score, dealer_score, result, busy
  );
endinterface

// File: rtl/card_rank_decode.sv
// Maps a random sample onto a card of the 52-card deck: range check, rank
// (ace = 1 .. king = 13) and blackjack points (face cards count 10).
module card_rank_decode
  import blackjack_pkg::*;
#(
  parameter int RND_W = 6
) (
  input  logic [RND_W-1:0] i_rnd,
  output logic             o_valid_range,
  output logic [3:0]       o_rank,
  output logic [3:0]       o_points
);
  logic [3:0] w_mod;

  assign w_mod         = 4'(i_rnd % RND_W'(13));
  assign o_valid_range = (i_rnd < RND_W'(DECK_SIZE));
  assign o_rank        = w_mod + 4'd1;
  assign o_points      = (o_rank > 4'd10) ? 4'd10 : o_rank;
endmodule

// File: rtl/blackjack_hand_fsm.sv
// One round of blackjack: draws unique cards from the LFSR stream, scores
// both hands with soft-ace handling and reports the round outcome.
module blackjack_hand_fsm
  import blackjack_pkg::*;
#(
  parameter int RND_W        = 6,
  parameter int DEALER_STAND = 17,
  parameter int SCORE_W      = 7
) (
  input logic              clk,
  input logic              reset,
  blackjack_hand_fsm_if.slave bus
);
  localparam int SLOTS = 2 ** RND_W;

  logic [3:0]           r_state;
  logic [DECK_SIZE-1:0] r_used;
  logic [4:0]           r_p_hard;
  logic [4:0]           r_d_hard;
  logic [4:0]           r_d_up;
  logic                 r_p_ace;
  logic                 r_d_ace;
  logic                 r_show_full;
  logic [1:0]           r_result;

  logic                 w_valid_range;
  logic [3:0]           w_rank;
  logic [3:0]           w_points;
  logic [SLOTS-1:0]     w_used_ext;
  logic [DECK_SIZE-1:0] w_card_onehot;
  logic                 w_draw_state;
  logic                 w_to_player;
  logic                 w_accept;
  logic                 w_is_ace;
  logic [4:0]           w_p_hard_next;
  logic [4:0]           w_d_hard_next;
  logic [4:0]           w_p_best;
  logic [4:0]           w_d_best;
  logic [4:0]           w_p_best_next;
  logic [4:0]           w_up_best;
  logic [1:0]           w_outcome;

  card_rank_decode #(.RND_W(RND_W)) u_decode (
    .i_rnd         (bus.rnd),
    .o_valid_range (w_valid_range),
    .o_rank        (w_rank),
    .o_points      (w_points)
  );

  // Pad the used mask to the full sample space so any sample can index it.
  for (genvar gi = 0; gi < SLOTS; gi++) begin : g_slot
    if (gi < DECK_SIZE) begin : g_card
      assign w_used_ext[gi] = r_used[gi];
    end else begin : g_pad
      assign w_used_ext[gi] = 1'b0;
    end
  end

  for (genvar gi = 0; gi < DECK_SIZE; gi++) begin : g_onehot
    assign w_card_onehot[gi] = (bus.rnd == RND_W'(gi));
  end

  assign w_draw_state = r_state inside {ST_DEAL_P1, ST_DEAL_D1, ST_DEAL_P2,
                                        ST_DEAL_D2, ST_P_DRAW, ST_D_DRAW};
  assign w_to_player  = r_state inside {ST_DEAL_P1, ST_DEAL_P2, ST_P_DRAW};
  assign w_accept     = w_draw_state && w_valid_range && !w_used_ext[bus.rnd];
  assign w_is_ace     = (w_rank == 4'd1);

  assign w_p_hard_next = r_p_hard + {1'b0, w_points};
  assign w_d_hard_next = r_d_hard + {1'b0, w_points};
  assign w_p_best      = best_score(r_p_hard, r_p_ace);
  assign w_d_best      = best_score(r_d_hard, r_d_ace);
  assign w_p_best_next = best_score(w_p_hard_next, r_p_ace | w_is_ace);
  assign w_up_best     = best_score({1'b0, w_points}, w_is_ace);

  always_comb begin
    w_outcome = RES_PUSH;
    if (w_d_best > 5'(BUST_LIMIT) || w_p_best > w_d_best) begin
      w_outcome = RES_PLAYER;
    end else if (w_p_best < w_d_best) begin
      w_outcome = RES_DEALER;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_used      <= '0;
      r_p_hard    <= '0;
      r_p_ace     <= 1'b0;
      r_d_hard    <= '0;
      r_d_ace     <= 1'b0;
      r_d_up      <= '0;
      r_show_full <= 1'b0;
      r_result    <= RES_NONE;
    end else begin
      // Accepted cards land on whichever hand the current draw state serves.
      if (w_accept) begin
        r_used <= r_used | w_card_onehot;
        if (w_to_player) begin
          r_p_hard <= w_p_hard_next;
          r_p_ace  <= r_p_ace | w_is_ace;
        end else begin
          r_d_hard <= w_d_hard_next;
          r_d_ace  <= r_d_ace | w_is_ace;
        end
      end

      case (r_state)
        ST_IDLE, ST_RESULT: begin
          if (bus.deal) begin
            r_used      <= '0;
            r_p_hard    <= '0;
            r_p_ace     <= 1'b0;
            r_d_hard    <= '0;
            r_d_ace     <= 1'b0;
            r_d_up      <= '0;
            r_show_full <= 1'b0;
            r_result    <= RES_NONE;
            r_state     <= ST_DEAL_P1;
          end
        end
        ST_DEAL_P1: if (w_accept) r_state <= ST_DEAL_D1;
        ST_DEAL_D1: begin
          if (w_accept) begin
            r_d_up  <= w_up_best;
            r_state <= ST_DEAL_P2;
          end
        end
        ST_DEAL_P2: if (w_accept) r_state <= ST_DEAL_D2;
        ST_DEAL_D2: if (w_accept) r_state <= ST_PLAYER_TURN;
        ST_PLAYER_TURN: begin
          if (bus.hit) begin
            r_state <= ST_P_DRAW;
          end else if (bus.stand) begin
            r_show_full <= 1'b1;
            r_state     <= ST_DEALER_TURN;
          end
        end
        ST_P_DRAW: begin
          if (w_accept) begin
            if (w_p_best_next > 5'(BUST_LIMIT)) begin
              r_result <= RES_DEALER;
              r_state  <= ST_RESULT;
            end else begin
              r_state <= ST_PLAYER_TURN;
            end
          end
        end
        ST_DEALER_TURN: begin
          if (w_d_best < 5'(DEALER_STAND)) begin
            r_state <= ST_D_DRAW;
          end else begin
            r_result <= w_outcome;
            r_state  <= ST_RESULT;
          end
        end
        ST_D_DRAW: if (w_accept) r_state <= ST_DEALER_TURN;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.player_score = SCORE_W'(w_p_best);
  assign bus.dealer_score = SCORE_W'(r_show_full ? w_d_best : r_d_up);
  assign bus.result       = r_result;
  assign bus.busy         = w_draw_state || (r_state == ST_DEALER_TURN);
endmodule

// File: doc/blackjack_hand_fsm.md
Name: blackjack_hand_fsm

Overview:
- Game-control stage sitting directly downstream of the 6-bit LFSR.
- Consumes the free-running random value, draws unique cards from a 52-card deck, and deals and scores one round of blackjack (player vs dealer).
- Produces 7-bit scores that feed the hex7seg display converters directly, plus a round result code.

Parameters:
- RND_W, 6, width of the random input from the LFSR.
- DEALER_STAND, 17, dealer stops hitting at score >= this (soft 17 stands).
- SCORE_W, 7, width of the score outputs (matches the hex7seg IN width).

Ports:
- clk  in  1  system clock (CLOCK_50 domain).
- reset  in  1  synchronous, active-high reset.
- rnd  in  RND_W  LFSR output; must change every clk cycle.
- deal  in  1  one-cycle pulse: start a new round.
- hit  in  1  one-cycle pulse: player draws one card.
- stand  in  1  one-cycle pulse: player ends turn.
- player_score  out  SCORE_W  player best score, zero-extended.
- dealer_score  out  SCORE_W  dealer score (upcard only until dealer turn).
- result  out  2  00 none, 01 player win, 10 dealer win, 11 push.
- busy  out  1  high while drawing or during the dealer turn.

Behaviour:
- Reset (sync, active-high, wins over everything):
  - state = IDLE; scores = 0; result = 00; busy = 0.
  - Used-card mask (52 bits) cleared; hard totals and ace flags cleared.
- Card draw, shared by all deals:
  - In a draw state, rnd is sampled every cycle.
  - A sample is accepted only if rnd <= 51 and used[rnd] == 0. Otherwise retry next cycle.
  - On accept: set used[rnd]; rank = (rnd mod 13) + 1; points = 1 for ace, 2..10 at face value, 10 for J/Q/K.
  - The target hard total and ace flag update on the same edge. Minimum latency is 1 cycle per card.
- Best score:
  - best = hard + 10 if the hand has an ace and hard <= 11; otherwise best = hard.
  - Hard total is 5 bits; maximum reachable value is 31.
- State machine:
  - IDLE: deal -> DEAL_P1.
  - DEAL_P1 -> DEAL_D1 -> DEAL_P2 -> DEAL_D2: each state draws one card and advances on accept.
  - DEAL_D2 -> PLAYER_TURN. Before entering, clear the used mask, totals, and result on the deal pulse.
  - PLAYER_TURN:
    - hit -> P_DRAW, which draws then returns to PLAYER_TURN.
    - If player best > 21 after any draw -> RESULT with 10; dealer turn skipped.
    - stand -> DEALER_TURN.
  - DEALER_TURN: if dealer best < DEALER_STAND -> D_DRAW and back; else -> RESULT.
  - RESULT:
    - Dealer best > 21 -> 01.
    - Otherwise compare: player > dealer -> 01; player < dealer -> 10; equal -> 11.
    - result holds until the next deal or reset. deal -> DEAL_P1.
- dealer_score shows the first dealer card's best value until DEALER_TURN is entered, then shows the full best score.
- busy = 1 in every DEAL_*, P_DRAW, D_DRAW, and DEALER_TURN state.
- Ignored inputs:
  - hit and stand are ignored outside PLAYER_TURN.
  - deal is ignored outside IDLE and RESULT.
  - If hit and stand arrive in the same cycle, hit wins.
- Deck exhaustion is impossible within one round (at most about 22 cards).
- The LFSR never emits 0, so card 0 is never drawn; this is accepted.
- A retry loop terminates because the LFSR visits all nonzero values within 63 cycles.
- Reset mid-round aborts immediately to the reset state; a deal in the same cycle is ignored.

Decomposition:
- Shared package blackjack_pkg holds:
  - State enum.
  - Result codes (RES_NONE, RES_PLAYER, RES_DEALER, RES_PUSH).
  - Constants BUST_LIMIT = 21, DECK_SIZE = 52, ACE_BONUS = 10.
- Sub-module card_rank_decode: combinational. Maps rnd to {valid_range, rank[3:0], points[3:0]}; the used-mask check stays in the FSM.

Test Plan:
- Reset, then rnd = 0,1,..: all outputs 0, state IDLE, busy = 0; hit and stand ignored.
- deal; bench forces rnd 0 (A), 9 (10), 12 (K), 5 (6) -> player_score = 21 (A + K soft), dealer_score shows 10 then 16 after stand. Dealer draws rnd 20 (8) -> dealer 24 bust -> result = 01.
- Rejection: during DEAL_P1 force rnd 60, 55, then 3 -> card accepted only on the third cycle; a later repeat of 3 is rejected and 4 accepted (used-mask check).
- Player bust: cards 9, 10 give player 20. hit with rnd 22 (10) -> player_score = 30, result = 10 the next cycle, dealer card never drawn.
- Push and soft ace: player 10 + 7 = 17, stand. Dealer holds A + 6 = soft 17 -> stands with no draw -> result = 11.
- Reset asserted mid-D_DRAW with deal high the same cycle -> IDLE, outputs 0, result = 00, mask clear on the next round.
